fifo_rd_stream: RTL and testbench

Read-side adapter between `fifo_sync` and a valid/ready stream consumer. It drains the FIFO through its `read_en`/`empty`/`data_out` port, where data arrives one cycle after the read. It presents the words in order on a valid/ready master interface through a 3-entry skid buffer. With a continuously ready consumer it sustains one word per cycle, and `fifo_rd_en` has no combinational path from `m_ready`.

---
 rtl/fifo_rd_stream.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter from a fifo_sync read port (one-cycle
// read latency) to a valid/ready stream master, decoupled by a 3-entry skid
// buffer. fifo_rd_en is computed only from registers, fifo_empty and reset,
// so there is no combinational path from m_ready to the FIFO.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the m_count port,
// a wrapping 32-bit count of accepted transfers.
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]      m_count
`endif
);

  logic [WIDTH-1:0] buf_q [3];
  logic [WIDTH-1:0] buf_d [3];
  logic [1:0]       rd_ptr_q;
  logic [1:0]       rd_ptr_d;
  logic [1:0]       wr_ptr_q;
  logic [1:0]       wr_ptr_d;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             inflight_q;
  logic             inflight_d;
  logic [2:0]       pending_s;
  logic             capture_s;
  logic             transfer_s;

  // Advance a buffer pointer around the three slots (2 wraps to 0).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    logic [1:0] r;
    case (p)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Issue a FIFO read only when a buffer slot is guaranteed for its word,
  // counting both held words and the word already in flight.
  always_comb begin
    pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
    if (reset) begin
      fifo_rd_en = 1'b0;
    end else if (fifo_empty) begin
      fifo_rd_en = 1'b0;
    end else if (pending_s < 3'd3) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // Present the head slot and derive the capture/transfer events.
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    transfer_s = m_valid && m_ready;
    capture_s  = inflight_q;
    case (rd_ptr_q)
      2'd0:    m_data = buf_q[0];
      2'd1:    m_data = buf_q[1];
      2'd2:    m_data = buf_q[2];
      default: m_data = {WIDTH{1'b0}};
    endcase
  end

  // Next-state: capture returned word, pop on transfer, track occupancy.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      buf_d[i] = buf_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;

    if (capture_s) begin
      case (wr_ptr_q)
        2'd0:    buf_d[0] = fifo_data;
        2'd1:    buf_d[1] = fifo_data;
        2'd2:    buf_d[2] = fifo_data;
        default: buf_d[0] = buf_q[0];
      endcase
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (transfer_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous capture and transfer leave the occupancy unchanged.
    case ({capture_s, transfer_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] count_q;

  // Count accepted transfers, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (transfer_s) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign m_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural fifo_sync model feeds the DUT, a
// queue of written words is the expected stream order, and an abstract
// "words requested but not yet delivered" count bounds the read issue.
module tb_fifo_rd_stream;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]  m_count;
`endif

  fifo_rd_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .m_count    (m_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model state and scoreboard
  logic [W-1:0] mem [4096];
  int           w_q = 0;
  int           r_q = 0;
  logic         wr_req;
  logic [W-1:0] wr_val;
  logic [W-1:0] exp_q [$];

  // Monitor state
  int           outstanding = 0;
  int           xfer_cnt    = 0;
  logic         prev_valid  = 1'b0;
  logic         prev_ready  = 1'b0;
  logic [W-1:0] prev_data   = '0;
  logic         prev_reset  = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (w_q == r_q);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural fifo_sync: data_out registered one cycle after read_en.
  initial fifo_data = '0;
  always @(posedge clk) begin
    if (fifo_rd_en) fifo_data <= mem[r_q];
    if (reset) begin
      w_q <= 0;
      r_q <= 0;
    end else begin
      if (wr_req) begin
        mem[w_q] <= wr_val;
        w_q <= w_q + 1;
        exp_q.push_back(wr_val);
      end
      if (fifo_rd_en) r_q <= r_q + 1;
    end
  end

  // Stream monitor: order, hold rule, read-issue bound and transfer count.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      xfer_cnt    = 0;
      prev_reset  = 1'b1;
    end else begin
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("m_count", m_count, xfer_cnt);
`endif
      if (!prev_reset && prev_valid && !prev_ready) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, prev_data);
      end
      if (fifo_rd_en) begin
        chk("rd_en_nonempty", fifo_empty, 1'b0);
        chk("rd_en_space", (outstanding < 3), 1'b1);
        outstanding++;
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) chk("order", m_data, exp_q.pop_front());
        xfer_cnt++;
        outstanding--;
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_reset = 1'b0;
    end
  end

  initial begin
    int pulses;
    int first;
    int last;
    int nv;
    int written;
    int cyc;
    logic [W-1:0] v;

    reset   = 1'b1;
    m_ready = 1'b1;
    wr_req  = 1'b0;
    wr_val  = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset with an empty FIFO
    for (int i = 0; i < 20; i++) begin
      chk("idle_valid", m_valid, 1'b0);
      chk("idle_data", m_data, 8'h00);
      chk("idle_rd_en", fifo_rd_en, 1'b0);
      tick();
    end

    // Latency: three words, consumer always ready
    wr_req = 1'b1; wr_val = 8'h11;
    tick();
    chk("lat_empty_fell", fifo_empty, 1'b0);
    chk("lat_rd_en_N", fifo_rd_en, 1'b1);
    chk("lat_valid_N", m_valid, 1'b0);
    wr_val = 8'h22;
    tick();
    chk("lat_valid_N1", m_valid, 1'b0);
    wr_val = 8'h33;
    tick();
    wr_req = 1'b0;
    chk("lat_valid_N2", m_valid, 1'b1);
    chk("lat_data_N2", m_data, 8'h11);
    tick();
    chk("lat_valid_N3", m_valid, 1'b1);
    chk("lat_data_N3", m_data, 8'h22);
    tick();
    chk("lat_valid_N4", m_valid, 1'b1);
    chk("lat_data_N4", m_data, 8'h33);
    tick();
    chk("lat_valid_N5", m_valid, 1'b0);

    // Throughput: 256 words streamed back to back
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 300; i++) begin
      wr_req = (i < 256);
      wr_val = i[W-1:0];
      if (m_valid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
      tick();
    end
    wr_req = 1'b0;
    chk("tp_count", nv, 256);
    chk("tp_no_gap", last - first, 255);

    // Backpressure: ten words, consumer stalled
    m_ready = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      wr_req = (i < 10);
      v      = 8'hA0 + 8'(i);
      wr_val = v;
      if (fifo_rd_en) pulses++;
      if (m_valid) chk("bp_data", m_data, 8'hA0);
      tick();
    end
    wr_req = 1'b0;
    chk("bp_pulses", pulses, 3);
    chk("bp_valid", m_valid, 1'b1);
    chk("bp_fifo_level", w_q - r_q, 7);

    // Restart: ten transfers without a bubble
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("rs_valid", m_valid, 1'b1);
      tick();
    end
    chk("rs_drained", m_valid, 1'b0);

    // Random writes and random backpressure, 1000 words
    written = 0;
    cyc     = 0;
    while ((written < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      wr_req  = (written < 1000) && ($urandom_range(0, 1) == 1);
      wr_val  = W'($urandom);
      if (wr_req) written++;
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    wr_req  = 1'b0;
    m_ready = 1'b1;
    chk("rand_drained", exp_q.size(), 0);
    tick();
    chk("rand_idle", m_valid, 1'b0);

    // Reset mid-operation with two words held and one in flight
    m_ready = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 50 && pulses < 3; i++) begin
      wr_req = (i < 5);
      v      = 8'hC0 + 8'(i);
      wr_val = v;
      if (fifo_rd_en) pulses++;
      tick();
    end
    wr_req = 1'b0;
    chk("mr_pulses", pulses, 3);
    chk("mr_valid_before", m_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_valid", m_valid, 1'b0);
    chk("mr_data", m_data, 8'h00);
    chk("mr_rd_en", fifo_rd_en, 1'b0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("mr_count", m_count, 32'd0);
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_stale", m_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
